// File: rtl/evict_packet_serializer_pkg.sv
// Shared types for the eviction transmit path: packet layout, header layout
// and serializer FSM states.
`ifndef EVICT_PACKET_WIDTH
`define EVICT_PACKET_WIDTH 784
`endif
`ifndef EVICT_BEAT_WIDTH
`define EVICT_BEAT_WIDTH 64
`endif

package evict_packet_serializer_pkg;

  localparam int EVICT_PKT_W  = `EVICT_PACKET_WIDTH;
  localparam int EVICT_BEAT_W = `EVICT_BEAT_WIDTH;

  localparam logic [7:0] EVICT_HDR_MAGIC = 8'hE5;

  typedef enum logic [1:0] {
    S_SER_IDLE,
    S_SER_HDR,
    S_SER_BODY
  } ser_state_e;

  // smac sits at the LSBs so it is the first data beat on the link
  typedef struct packed {
    logic [63:0]  addr;
    logic [79:0]  comb_cnt;
    logic [511:0] line;
    logic [127:0] smac;
  } evict_packet_s;

  typedef struct packed {
    logic [EVICT_BEAT_W-33:0] pad;
    logic [7:0]               nbeats;
    logic [15:0]              seq;
    logic [7:0]               magic;
  } evict_hdr_s;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/evict_beat_mux.sv
// Selects one BEAT_W slice of the held packet; the final beat is zero-padded
// above PKT_W.
module evict_beat_mux
  import evict_packet_serializer_pkg::*;
#(
  parameter int PKT_W  = EVICT_PKT_W,
  parameter int BEAT_W = EVICT_BEAT_W,
  parameter int NBEATS = ceil_div(EVICT_PKT_W, EVICT_BEAT_W),
  parameter int IDX_W  = 4
) (
  input  logic [PKT_W-1:0]  pkt,
  input  logic [IDX_W-1:0]  idx,
  output logic [BEAT_W-1:0] beat
);

  localparam int PAD_W = NBEATS * BEAT_W;

  logic [PAD_W-1:0] padded;

  assign padded = PAD_W'(pkt);

  always_comb begin
    beat = '0;
    for (int b = 0; b < NBEATS; b++) begin
      if (idx == IDX_W'(b)) beat = padded[b*BEAT_W +: BEAT_W];
    end
  end

endmodule

// File: rtl/evict_packet_serializer.sv
// Serializes one evict_packet_s per handshake into a header beat followed by
// NBEATS data beats on a narrow valid/ready link.
module evict_packet_serializer
  import evict_packet_serializer_pkg::*;
#(
  parameter int BEAT_W = EVICT_BEAT_W,
  parameter int PKT_W  = EVICT_PKT_W,
  parameter int SEQ_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [PKT_W-1:0]  pkt_in,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [BEAT_W-1:0] beat_data,
  output logic              beat_first,
  output logic              beat_last,
  output logic [SEQ_W-1:0]  seq_out,
  output logic              busy
);

  localparam int NBEATS = ceil_div(PKT_W, BEAT_W);
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  ser_state_e        state;
  logic [PKT_W-1:0]  held_pkt;
  logic [IDX_W-1:0]  idx;
  logic [SEQ_W-1:0]  seq_cnt;
  logic [IDX_W-1:0]  mux_idx;
  logic [SEQ_W-1:0]  hdr_seq;
  logic [BEAT_W-1:0] mux_beat;

  function automatic logic [BEAT_W-1:0] make_hdr(input logic [SEQ_W-1:0] s);
    evict_hdr_s h;
    h        = '0;
    h.nbeats = 8'(NBEATS);
    h.seq    = 16'(s);
    h.magic  = EVICT_HDR_MAGIC;
    return BEAT_W'(h);
  endfunction

  // Data registers load the beat that will be presented after the handshake,
  // so the mux looks one index ahead and the header uses the post-increment seq.
  always_comb begin
    mux_idx = '0;
    hdr_seq = seq_cnt;
    if (state == S_SER_BODY) begin
      mux_idx = idx + 1'b1;
      hdr_seq = seq_cnt + 1'b1;
    end
  end

  evict_beat_mux #(
    .PKT_W (PKT_W),
    .BEAT_W(BEAT_W),
    .NBEATS(NBEATS),
    .IDX_W (IDX_W)
  ) u_beat_mux (
    .pkt (held_pkt),
    .idx (mux_idx),
    .beat(mux_beat)
  );

  assign pkt_ready = (state == S_SER_IDLE) ||
                     ((state == S_SER_BODY) && beat_last && beat_ready);
  assign seq_out   = seq_cnt;
  assign busy      = (state != S_SER_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_SER_IDLE;
      held_pkt   <= '0;
      idx        <= '0;
      seq_cnt    <= '0;
      beat_valid <= 1'b0;
      beat_first <= 1'b0;
      beat_last  <= 1'b0;
      beat_data  <= '0;
    end else begin
      case (state)
        S_SER_IDLE: begin
          if (pkt_valid) begin
            held_pkt   <= pkt_in;
            state      <= S_SER_HDR;
            beat_valid <= 1'b1;
            beat_first <= 1'b1;
            beat_last  <= 1'b0;
            beat_data  <= make_hdr(hdr_seq);
          end
        end
        S_SER_HDR: begin
          if (beat_ready) begin
            state      <= S_SER_BODY;
            idx        <= '0;
            beat_first <= 1'b0;
            beat_last  <= (NBEATS == 1);
            beat_data  <= mux_beat;
          end
        end
        S_SER_BODY: begin
          if (beat_ready) begin
            if (idx == LAST_IDX) begin
              seq_cnt <= seq_cnt + 1'b1;
              if (pkt_valid) begin
                held_pkt   <= pkt_in;
                state      <= S_SER_HDR;
                beat_first <= 1'b1;
                beat_last  <= 1'b0;
                beat_data  <= make_hdr(hdr_seq);
              end else begin
                state      <= S_SER_IDLE;
                beat_valid <= 1'b0;
                beat_last  <= 1'b0;
                beat_data  <= '0;
              end
            end else begin
              idx       <= idx + 1'b1;
              beat_last <= (idx + 1'b1 == LAST_IDX);
              beat_data <= mux_beat;
            end
          end
        end
        default: state <= S_SER_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evict_packet_serializer.sv
// Scoreboard bench for evict_packet_serializer: stimulus pushes expected beats,
// a negedge monitor pops and compares on every beat handshake.
module tb_evict_packet_serializer;
  import evict_packet_serializer_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic        first;
    logic        last;
    logic [15:0] seq;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         pkt_valid;
  logic         pkt_ready;
  logic [783:0] pkt_in;
  logic         beat_valid;
  logic         beat_ready;
  logic [63:0]  beat_data;
  logic         beat_first;
  logic         beat_last;
  logic [15:0]  seq_out;
  logic         busy;

  exp_t        sb[$];
  int          n_vectors;
  int          n_miss;
  int          hs_count;
  logic [15:0] tb_seq;
  logic        rand_mode;
  logic        ready_level;

  logic        stalled_prev;
  logic [63:0] stall_data;
  logic        stall_first;
  logic        stall_last;
  logic [15:0] stall_seq;

  evict_packet_serializer #(
    .BEAT_W(64),
    .PKT_W (784),
    .SEQ_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_in    (pkt_in),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_data (beat_data),
    .beat_first(beat_first),
    .beat_last (beat_last),
    .seq_out   (seq_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_vectors++;
    n_miss++;
    $display("[TB] FAIL %s: timed out, expected completion", name);
  endtask

  function automatic logic [63:0] hdrBeat(input logic [15:0] s);
    return {32'h0, 8'd13, s, 8'hE5};
  endfunction

  function automatic evict_packet_s rndPkt();
    logic [799:0] r;
    for (int i = 0; i < 25; i++) r[i*32 +: 32] = $urandom;
    return evict_packet_s'(r[783:0]);
  endfunction

  // Reference slicing: the 784-bit packet zero-extended to 13 beats, LSB first.
  task automatic pushPacket(input evict_packet_s p, input logic [15:0] s);
    logic [831:0] padded;
    exp_t e;
    padded  = {48'h0, p};
    e.data  = hdrBeat(s);
    e.first = 1'b1;
    e.last  = 1'b0;
    e.seq   = s;
    sb.push_back(e);
    for (int b = 0; b < 13; b++) begin
      e.data  = padded[b*64 +: 64];
      e.first = 1'b0;
      e.last  = (b == 12);
      sb.push_back(e);
    end
  endtask

  task automatic pushLiteral(input logic [63:0] d, input logic f, input logic l, input logic [15:0] s);
    exp_t e;
    e.data  = d;
    e.first = f;
    e.last  = l;
    e.seq   = s;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the packet handshake.
  task automatic applyStimulus(input evict_packet_s p, input bit keep, input bit push);
    bit ok;
    pkt_in    = p;
    pkt_valid = 1'b1;
    if (push) pushPacket(p, tb_seq);
    tb_seq = tb_seq + 16'd1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pkt_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportTimeout("pkt_accept");
    @(posedge clk);
    #1;
    if (!keep || !ok) pkt_valid = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportTimeout("drain");
  endtask

  always @(posedge clk) begin
    #1;
    beat_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Monitor: compare every handshaken beat and check stability across stalls.
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        checkOutput("stall_hold",
                    {beat_valid, beat_first, beat_last, beat_data[44:0], seq_out},
                    {1'b1, stall_first, stall_last, stall_data[44:0], stall_seq});
        checkOutput("stall_data", beat_data, stall_data);
      end
      if (beat_valid && beat_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          n_vectors++;
          n_miss++;
          $display("[TB] FAIL unexpected_beat: got %h, expected no beat", beat_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("beat_data", beat_data, e.data);
          checkOutput("beat_flags", {62'h0, beat_first, beat_last}, {62'h0, e.first, e.last});
          checkOutput("seq_out", {48'h0, seq_out}, {48'h0, e.seq});
        end
      end
      stalled_prev = beat_valid && !beat_ready;
      stall_data   = beat_data;
      stall_first  = beat_first;
      stall_last   = beat_last;
      stall_seq    = seq_out;
    end
  end

  initial begin
    evict_packet_s p;
    evict_packet_s q;
    n_vectors    = 0;
    n_miss       = 0;
    hs_count     = 0;
    tb_seq       = 16'h0;
    rand_mode    = 1'b0;
    ready_level  = 1'b0;
    stalled_prev = 1'b0;
    rst          = 1'b1;
    pkt_valid    = 1'b0;
    pkt_in       = '0;
    beat_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_ready", {63'h0, pkt_ready}, 64'h1);
    checkOutput("rst_valid", {61'h0, beat_valid, beat_first, beat_last}, 64'h0);
    checkOutput("rst_data", beat_data, 64'h0);
    checkOutput("rst_seq_busy", {47'h0, busy, seq_out}, 64'h0);

    // Hand-computed packet: smac A5.., line 0, comb_cnt all ones, small addr.
    $display("[TB] single packet, hand-computed beats");
    ready_level = 1'b1;
    @(posedge clk);
    #1;
    p.addr     = 64'h0000_1234_5678_9ABC;
    p.comb_cnt = '1;
    p.line     = '0;
    p.smac     = {16{8'hA5}};
    pushLiteral(64'h0000_0000_0D00_00E5, 1'b1, 1'b0, 16'h0);
    pushLiteral(64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b0, 16'h0);
    pushLiteral(64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) pushLiteral(64'h0, 1'b0, 1'b0, 16'h0);
    pushLiteral(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 16'h0);
    pushLiteral(64'h1234_5678_9ABC_FFFF, 1'b0, 1'b0, 16'h0);
    pushLiteral(64'h0000_0000_0000_0000, 1'b0, 1'b1, 16'h0);
    applyStimulus(p, 1'b0, 1'b0);
    waitDrain(100);
    checkOutput("idle_ready", {62'h0, pkt_ready, busy}, 64'h2);

    $display("[TB] back-to-back packets");
    @(posedge clk);
    #1;
    p = rndPkt();
    q = rndPkt();
    applyStimulus(p, 1'b1, 1'b1);
    applyStimulus(q, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("no_gap_hdr", {62'h0, beat_valid, beat_first}, 64'h3);
    checkOutput("no_gap_data", beat_data, 64'h0000_0000_0D00_02E5);
    waitDrain(100);

    $display("[TB] pkt_in changes after acceptance");
    @(posedge clk);
    #1;
    p = rndPkt();
    applyStimulus(p, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 pkt_in = rndPkt();
    end
    waitDrain(100);

    $display("[TB] random beat_ready stalls");
    rand_mode = 1'b1;
    @(posedge clk);
    #1;
    p = rndPkt();
    q = rndPkt();
    applyStimulus(p, 1'b1, 1'b1);
    applyStimulus(q, 1'b0, 1'b1);
    waitDrain(400);
    rand_mode = 1'b0;

    $display("[TB] reset during beat 6");
    @(posedge clk);
    #1;
    p = rndPkt();
    hs_count = 0;
    applyStimulus(p, 1'b0, 1'b1);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (hs_count >= 6) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      if (!ok) reportTimeout("reach_beat6");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    tb_seq = 16'h0;
    @(negedge clk);
    checkOutput("midrst_outputs", {60'h0, beat_valid, pkt_ready, busy, beat_last}, 64'h4);
    checkOutput("midrst_seq", {48'h0, seq_out}, 64'h0);
    @(posedge clk);
    #1;
    p = rndPkt();
    applyStimulus(p, 1'b0, 1'b1);
    waitDrain(100);

    $display("[TB] sequence wrap");
    @(posedge clk);
    #1;
    dut.seq_cnt = 16'hFFFF;
    tb_seq = 16'hFFFF;
    p = rndPkt();
    q = rndPkt();
    applyStimulus(p, 1'b1, 1'b1);
    applyStimulus(q, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_hdr", beat_data, 64'h0000_0000_0D00_00E5);
    waitDrain(100);

    checkOutput("sb_empty", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
    $finish;
  end

endmodule

// File: doc/evict_packet_serializer.md
Name: evict_packet_serializer

Overview:
- Transmit end of the eviction path: accepts one whole `evict_packet_s` (addrcnt + line + smac, 784 bits) per handshake and emits it as a header beat followed by fixed-width data beats on a narrow valid/ready link toward the off-chip memory/verifier side.
- Sits between the victim/evict-stack logic and the external link. It is the counterpart of the link deserializer, which reassembles `evict_packet_s` from these beats.

Parameters:
- BEAT_W, 64, link data width in bits; multiple of 8, ≥32.
- PKT_W, 784, packed width of `evict_packet_s` (ADDR 64 + COMB_CNT 80 + LINE 512 + SMAC 128).
- SEQ_W, 16, width of the per-packet sequence number carried in the header.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- pkt_valid, in, 1, `evict_packet_s` on `pkt_in` is valid.
- pkt_ready, out, 1, serializer accepts `pkt_in` this cycle.
- pkt_in, in, PKT_W, packed `evict_packet_s`.
- beat_valid, out, 1, `beat_data` valid.
- beat_ready, in, 1, link accepts beat.
- beat_data, out, BEAT_W, header or data beat.
- beat_first, out, 1, current beat is the header.
- beat_last, out, 1, current beat is the final data beat.
- seq_out, out, SEQ_W, sequence number of the packet currently in flight.
- busy, out, 1, a packet is held (not idle).

Behaviour:
- Single clock domain; synchronous active-high reset.
- Derived constant: NBEATS = ceil(PKT_W/BEAT_W) (13 at defaults).
- Reset values: pkt_ready=1, beat_valid=0, beat_first=0, beat_last=0, beat_data=0, seq_out=0, busy=0, internal seq counter=0, beat index=0.
- FSM states:
  - S_IDLE: pkt_ready=1. On pkt_valid, latch pkt_in into the holding register → S_HDR. Latency: first header beat is valid the cycle after acceptance.
  - S_HDR: beat_valid=1, beat_first=1. beat_data = {zeros, NBEATS[7:0] at [31:24], seq[15:0] at [23:8], 8'hE5 at [7:0]}. On beat_ready → S_BODY, idx=0.
  - S_BODY: beat_valid=1. beat_data = held_pkt[idx*BEAT_W +: BEAT_W] (LSB-first, smac first). Bits beyond PKT_W in the final beat are zero.
    - beat_last=1 when idx==NBEATS-1.
    - On beat_ready with idx<NBEATS-1: idx++.
    - On beat_ready with idx==NBEATS-1: seq++ (wraps at 2^SEQ_W, i.e. 16'hFFFF→0). Then → S_HDR if a new packet is accepted this cycle, else → S_IDLE.
- Back-to-back packets:
  - pkt_ready=1 also in S_BODY when beat_last & beat_ready. A new packet is latched in the same cycle, with no bubble between its header and the previous last beat.
  - pkt_ready=0 in all other cycles.
- Stall rule: while beat_valid=1 and beat_ready=0, beat_data, beat_first, beat_last and seq_out hold stable. beat_valid never drops before the handshake.
- pkt_in is sampled only on pkt_valid&pkt_ready. Later changes to pkt_in do not affect the held packet.
- seq_out equals the seq value placed in the current header and stays constant through that packet's body beats.
- busy = (state != S_IDLE).
- Reset mid-packet: the packet is dropped with no further beats, all outputs return to reset values next cycle, and seq restarts at 0.
- Simultaneous rst and handshakes: rst wins.

Decomposition:
- Add to shared package TYPES:
  - `ser_state_e {S_SER_IDLE, S_SER_HDR, S_SER_BODY}`
  - `EVICT_HDR_MAGIC` = 8'hE5
  - `evict_hdr_s` = packed {zero pad, nbeats[7:0], seq[15:0], magic[7:0]}
  - `` `EVICT_PACKET_WIDTH`` and `` `EVICT_BEAT_WIDTH`` macros
- The module consumes `evict_packet_s` directly.
- One natural sub-module: `evict_beat_mux`, the combinational indexed slice of held_pkt with zero-pad of the final beat. Everything else lives in the top FSM.

Test Plan:
- Reset, then one packet with addr=64'h0000_1234_5678_9ABC, comb_cnt=all 1s, line=512'h0, smac=128'hA5 repeated, beat_ready=1:
  - 14 beats; beat0=64'h0000_0000_0D00_00E5 with beat_first=1.
  - beat1=64'hA5A5_A5A5_A5A5_A5A5.
  - beat13 = {48'h0, 16'h0000} with beat_last=1.
  - pkt_ready=1 thereafter.
- Two packets with pkt_valid held high → second header 64'h0000_0000_0D00_01E5 appears the cycle after the first packet's beat_last handshake; no idle gap.
- beat_ready toggled randomly at 50% → beat_data/first/last stable during every stall; reassembled 784 bits equal the input.
- Change pkt_in while in S_BODY → emitted beats still match the latched packet.
- Assert rst during beat 6 → next cycle beat_valid=0 and pkt_ready=1; the following packet's header carries seq=0.
- Force seq counter to 16'hFFFF (send 65535 packets or backdoor) → that packet's header carries seq FFFF and the next header carries seq 0000.
